// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit -- EX-stage operand forwarding and load-use hazard unit for
// the 5-stage RV32I pipeline.
//
// Each of NUM_RS source operands of the ID/EX instruction is served from, in
// priority order: EX/MEM (non-load), MEM/WB (load data already extracted),
// the retirement hold buffer (newest first), then the register-file value
// latched into ID/EX. A source matching a live EX/MEM load raises
// load_use_stall.
//
// The hold buffer catches writebacks that retire while ID/EX is held. Without
// it, a held instruction would miss a result whose register-file write it
// read too early. The buffer empties whenever ID/EX takes a new instruction.
//
// Writeback select encoding (regfilemux_sel_t, 4 bits):
//   0 alu_out, 1 br_en, 2 u_imm, 3 lw, 4 pc_plus4, 5 lb, 6 lbu, 7 lh, 8 lhu
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pipe_freeze         global freeze; no state changes
//   id_ex_advance       ID/EX latches a new instruction this cycle
//   id_ex_rs_addr/data  per-operand source address / register-file value
//   ex_mem_*            EX/MEM valid, we, rd, writeback select, result
//   mem_wb_*            MEM/WB valid, we, rd, select, result, load word, addr[1:0]
//   fwd_data, fwd_src   forwarded operands and their source (0 rf, 1 EX/MEM,
//                       2 MEM/WB, 3 hold)
//   load_use_stall      hold IF/ID and ID/EX, bubble into EX/MEM
//   hold_overflow       sticky: a push found the hold buffer full
//
// Optional build macro FWD_PERF_CNT_EN adds saturating counters
// perf_lu_stall_cnt and perf_fwd_cnt.

// Per-operand forwarding mux. Assignments go from lowest to highest priority,
// so the last matching source wins.
module fwd_lane #(
   parameter int XLEN       = 32,
   parameter int HOLD_DEPTH = 2
) (
   input  logic [4:0]               rs_addr,
   input  logic [XLEN-1:0]          rf_data,
   input  logic                     ex_live,
   input  logic                     ex_is_load,
   input  logic [4:0]               ex_rd,
   input  logic [XLEN-1:0]          ex_val,
   input  logic                     wb_live,
   input  logic [4:0]               wb_rd,
   input  logic [XLEN-1:0]          wb_val,
   input  logic [HOLD_DEPTH-1:0]    hb_vld,
   input  logic [HOLD_DEPTH*5-1:0]  hb_rd,
   input  logic [HOLD_DEPTH*XLEN-1:0] hb_val,
   output logic [XLEN-1:0]          data,
   output logic [1:0]               src,
   output logic                     lu_hit
);
   always_comb begin
      data   = rf_data;
      src    = 2'd0;
      lu_hit = 1'b0;
      if (rs_addr == 5'd0) begin
         data = '0;
      end else begin
         // Higher index holds the newer entry.
         for (int i = 0; i < HOLD_DEPTH; i++) begin
            if (hb_vld[i] && hb_rd[i*5 +: 5] == rs_addr) begin
               data = hb_val[i*XLEN +: XLEN];
               src  = 2'd3;
            end
         end
         if (wb_live && wb_rd == rs_addr) begin
            data = wb_val;
            src  = 2'd2;
         end
         // A load in EX/MEM has no data yet: stall and leave data to the
         // lower-priority sources (the value is discarded anyway).
         if (ex_live && ex_rd == rs_addr) begin
            if (ex_is_load) begin
               lu_hit = 1'b1;
            end else begin
               data = ex_val;
               src  = 2'd1;
            end
         end
      end
   end
endmodule

module fwd_hazard_unit #(
   parameter int XLEN       = 32,
   parameter int NUM_RS     = 2,
   parameter int HOLD_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pipe_freeze,
   input  logic                   id_ex_advance,
   input  logic [NUM_RS*5-1:0]    id_ex_rs_addr,
   input  logic [NUM_RS*XLEN-1:0] id_ex_rs_data,
   input  logic                   ex_mem_valid,
   input  logic                   ex_mem_we,
   input  logic [4:0]             ex_mem_rd,
   input  logic [3:0]             ex_mem_regfile_sel,
   input  logic [XLEN-1:0]        ex_mem_result,
   input  logic                   mem_wb_valid,
   input  logic                   mem_wb_we,
   input  logic [4:0]             mem_wb_rd,
   input  logic [3:0]             mem_wb_regfile_sel,
   input  logic [XLEN-1:0]        mem_wb_result,
   input  logic [XLEN-1:0]        mem_wb_mem_rdata,
   input  logic [1:0]             mem_wb_addr_lo,
   output logic [NUM_RS*XLEN-1:0] fwd_data,
   output logic [NUM_RS*2-1:0]    fwd_src,
   output logic                   load_use_stall,
`ifdef FWD_PERF_CNT_EN
   output logic [31:0]            perf_lu_stall_cnt,
   output logic [31:0]            perf_fwd_cnt,
`endif
   output logic                   hold_overflow
);
   localparam logic [3:0] SEL_LW  = 4'd3;
   localparam logic [3:0] SEL_LB  = 4'd5;
   localparam logic [3:0] SEL_LBU = 4'd6;
   localparam logic [3:0] SEL_LH  = 4'd7;
   localparam logic [3:0] SEL_LHU = 4'd8;

   function automatic logic is_load(input logic [3:0] sel);
      return sel inside {SEL_LW, SEL_LB, SEL_LBU, SEL_LH, SEL_LHU};
   endfunction

   logic ex_live, wb_live, retire, push, clear;
   assign ex_live = ex_mem_valid && ex_mem_we && (ex_mem_rd != 5'd0);
   assign wb_live = mem_wb_valid && mem_wb_we && (mem_wb_rd != 5'd0);
   assign retire  = wb_live && !pipe_freeze;
   assign push    = retire && !id_ex_advance;
   assign clear   = id_ex_advance && !pipe_freeze;

   // MEM/WB writeback value with load extraction.
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] wb_val;
   always_comb begin
      case (mem_wb_addr_lo)
         2'd0:    ld_byte = mem_wb_mem_rdata[7:0];
         2'd1:    ld_byte = mem_wb_mem_rdata[15:8];
         2'd2:    ld_byte = mem_wb_mem_rdata[23:16];
         default: ld_byte = mem_wb_mem_rdata[31:24];
      endcase
      ld_half = mem_wb_addr_lo[1] ? mem_wb_mem_rdata[31:16] : mem_wb_mem_rdata[15:0];
      case (mem_wb_regfile_sel)
         SEL_LB:  wb_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         SEL_LBU: wb_val = {{(XLEN-8){1'b0}}, ld_byte};
         SEL_LH:  wb_val = {{(XLEN-16){ld_half[15]}}, ld_half};
         SEL_LHU: wb_val = {{(XLEN-16){1'b0}}, ld_half};
         SEL_LW:  wb_val = mem_wb_mem_rdata;
         default: wb_val = mem_wb_result;
      endcase
   end

   // Hold buffer: valid entries form a prefix, index 0 oldest.
   logic [HOLD_DEPTH-1:0]           hb_vld_q, hb_vld_d;
   logic [HOLD_DEPTH-1:0][4:0]      hb_rd_q, hb_rd_d;
   logic [HOLD_DEPTH-1:0][XLEN-1:0] hb_val_q, hb_val_d;
   logic                            ov_set;

   always_comb begin
      logic done;
      hb_vld_d = hb_vld_q;
      hb_rd_d  = hb_rd_q;
      hb_val_d = hb_val_q;
      ov_set   = 1'b0;
      done     = 1'b0;
      if (clear) begin
         hb_vld_d = '0;
      end else if (push) begin
         // Same rd: refresh the value in place so rd stays unique.
         for (int i = 0; i < HOLD_DEPTH; i++) begin
            if (!done && hb_vld_q[i] && hb_rd_q[i] == mem_wb_rd) begin
               hb_val_d[i] = wb_val;
               done        = 1'b1;
            end
         end
         for (int i = 0; i < HOLD_DEPTH; i++) begin
            if (!done && !hb_vld_q[i]) begin
               hb_vld_d[i] = 1'b1;
               hb_rd_d[i]  = mem_wb_rd;
               hb_val_d[i] = wb_val;
               done        = 1'b1;
            end
         end
         // Full with no match: shift out the oldest, append at the top.
         if (!done) begin
            for (int i = 0; i < HOLD_DEPTH-1; i++) begin
               hb_rd_d[i]  = hb_rd_q[i+1];
               hb_val_d[i] = hb_val_q[i+1];
            end
            hb_rd_d[HOLD_DEPTH-1]  = mem_wb_rd;
            hb_val_d[HOLD_DEPTH-1] = wb_val;
            ov_set                 = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hb_vld_q      <= '0;
         hb_rd_q       <= '0;
         hb_val_q      <= '0;
         hold_overflow <= 1'b0;
      end else begin
         hb_vld_q <= hb_vld_d;
         hb_rd_q  <= hb_rd_d;
         hb_val_q <= hb_val_d;
         if (ov_set) hold_overflow <= 1'b1;
      end
   end

   logic [NUM_RS-1:0] lu_hit;
   logic              ex_is_load;
   assign ex_is_load = is_load(ex_mem_regfile_sel);

   for (genvar g = 0; g < NUM_RS; g++) begin : g_lane
      fwd_lane #(.XLEN(XLEN), .HOLD_DEPTH(HOLD_DEPTH)) u_lane (
         .rs_addr    (id_ex_rs_addr[g*5 +: 5]),
         .rf_data    (id_ex_rs_data[g*XLEN +: XLEN]),
         .ex_live    (ex_live),
         .ex_is_load (ex_is_load),
         .ex_rd      (ex_mem_rd),
         .ex_val     (ex_mem_result),
         .wb_live    (wb_live),
         .wb_rd      (mem_wb_rd),
         .wb_val     (wb_val),
         .hb_vld     (hb_vld_q),
         .hb_rd      (hb_rd_q),
         .hb_val     (hb_val_q),
         .data       (fwd_data[g*XLEN +: XLEN]),
         .src        (fwd_src[g*2 +: 2]),
         .lu_hit     (lu_hit[g])
      );
   end

   assign load_use_stall = |lu_hit;

`ifdef FWD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_lu_stall_cnt <= '0;
         perf_fwd_cnt      <= '0;
      end else if (!pipe_freeze) begin
         if (load_use_stall && perf_lu_stall_cnt != 32'hFFFF_FFFF)
            perf_lu_stall_cnt <= perf_lu_stall_cnt + 32'd1;
         if ((|fwd_src) && perf_fwd_cnt != 32'hFFFF_FFFF)
            perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. Instance a uses HOLD_DEPTH=2, instance b
// HOLD_DEPTH=1; both share all inputs so overflow behaviour can be compared.
module tb_fwd_hazard_unit;
   localparam logic [3:0] S_ALU = 4'd0, S_LW = 4'd3, S_LB = 4'd5,
                          S_LBU = 4'd6, S_LH = 4'd7, S_LHU = 4'd8;

   logic        clk = 1'b0;
   logic        rst, pipe_freeze, id_ex_advance;
   logic [9:0]  rs_addr;
   logic [63:0] rs_data;
   logic        ex_valid, ex_we, wb_valid, wb_we;
   logic [4:0]  ex_rd, wb_rd;
   logic [3:0]  ex_sel, wb_sel;
   logic [31:0] ex_res, wb_res, wb_rdata;
   logic [1:0]  wb_alo;

   logic [63:0] fd_a, fd_b;
   logic [3:0]  fs_a, fs_b;
   logic        st_a, st_b, ov_a, ov_b;
`ifdef FWD_PERF_CNT_EN
   logic [31:0] plu_a, pfw_a, plu_b, pfw_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit #(.XLEN(32), .NUM_RS(2), .HOLD_DEPTH(2)) dut_a (
      .clk(clk), .rst(rst), .pipe_freeze(pipe_freeze), .id_ex_advance(id_ex_advance),
      .id_ex_rs_addr(rs_addr), .id_ex_rs_data(rs_data),
      .ex_mem_valid(ex_valid), .ex_mem_we(ex_we), .ex_mem_rd(ex_rd),
      .ex_mem_regfile_sel(ex_sel), .ex_mem_result(ex_res),
      .mem_wb_valid(wb_valid), .mem_wb_we(wb_we), .mem_wb_rd(wb_rd),
      .mem_wb_regfile_sel(wb_sel), .mem_wb_result(wb_res),
      .mem_wb_mem_rdata(wb_rdata), .mem_wb_addr_lo(wb_alo),
      .fwd_data(fd_a), .fwd_src(fs_a), .load_use_stall(st_a),
`ifdef FWD_PERF_CNT_EN
      .perf_lu_stall_cnt(plu_a), .perf_fwd_cnt(pfw_a),
`endif
      .hold_overflow(ov_a));

   fwd_hazard_unit #(.XLEN(32), .NUM_RS(2), .HOLD_DEPTH(1)) dut_b (
      .clk(clk), .rst(rst), .pipe_freeze(pipe_freeze), .id_ex_advance(id_ex_advance),
      .id_ex_rs_addr(rs_addr), .id_ex_rs_data(rs_data),
      .ex_mem_valid(ex_valid), .ex_mem_we(ex_we), .ex_mem_rd(ex_rd),
      .ex_mem_regfile_sel(ex_sel), .ex_mem_result(ex_res),
      .mem_wb_valid(wb_valid), .mem_wb_we(wb_we), .mem_wb_rd(wb_rd),
      .mem_wb_regfile_sel(wb_sel), .mem_wb_result(wb_res),
      .mem_wb_mem_rdata(wb_rdata), .mem_wb_addr_lo(wb_alo),
      .fwd_data(fd_b), .fwd_src(fs_b), .load_use_stall(st_b),
`ifdef FWD_PERF_CNT_EN
      .perf_lu_stall_cnt(plu_b), .perf_fwd_cnt(pfw_b),
`endif
      .hold_overflow(ov_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pipe_freeze = 1'b0; id_ex_advance = 1'b0;
      ex_valid = 1'b0; ex_we = 1'b0; ex_rd = 5'd0; ex_sel = S_ALU; ex_res = '0;
      wb_valid = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_sel = S_ALU; wb_res = '0;
      wb_rdata = '0; wb_alo = 2'd0;
   endtask

   task automatic ex_set(input logic [4:0] rd, input logic [3:0] sel, input logic [31:0] v);
      ex_valid = 1'b1; ex_we = 1'b1; ex_rd = rd; ex_sel = sel; ex_res = v;
   endtask

   task automatic wb_set(input logic [4:0] rd, input logic [3:0] sel, input logic [31:0] v);
      wb_valid = 1'b1; wb_we = 1'b1; wb_rd = rd; wb_sel = sel; wb_res = v;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      rs_addr = {5'd2, 5'd1};
      rs_data = {32'h22, 32'h11};
      tick();
      #1;
      // Reset state
      chk("rst_data0", fd_a[31:0], 32'h11);
      chk("rst_data1", fd_a[63:32], 32'h22);
      chk("rst_src", 32'(fs_a), 32'd0);
      chk("rst_stall", 32'(st_a), 32'd0);
      chk("rst_ov_a", 32'(ov_a), 32'd0);
      chk("rst_ov_b", 32'(ov_b), 32'd0);
      tick();
      rst = 1'b0;

      // EX/MEM ALU forward
      ex_set(5'd5, S_ALU, 32'h10);
      rs_addr = {5'd3, 5'd5}; rs_data = {32'h33, 32'h0};
      #1;
      chk("exfwd_data0", fd_a[31:0], 32'h10);
      chk("exfwd_src0", 32'(fs_a[1:0]), 32'd1);
      chk("exfwd_data1", fd_a[63:32], 32'h33);
      chk("exfwd_src1", 32'(fs_a[3:2]), 32'd0);
      chk("exfwd_stall", 32'(st_a), 32'd0);

      // Load-use on rs2, then MEM/WB load extraction
      tick();
      idle();
      ex_set(5'd6, S_LB, 32'h0);
      rs_addr = {5'd6, 5'd0}; rs_data = {32'h66, 32'h0};
      #1;
      chk("lu_stall", 32'(st_a), 32'd1);
      tick();
      idle();
      wb_set(5'd6, S_LB, 32'h0); wb_rdata = 32'h80FF_0000; wb_alo = 2'd3;
      #1;
      chk("lu_stall_gone", 32'(st_a), 32'd0);
      chk("lb_data", fd_a[63:32], 32'hFFFF_FF80);
      chk("lb_src", 32'(fs_a[3:2]), 32'd2);
      wb_sel = S_LBU; #1;
      chk("lbu_data", fd_a[63:32], 32'h0000_0080);
      wb_sel = S_LH; wb_alo = 2'd2; #1;
      chk("lh_data", fd_a[63:32], 32'hFFFF_80FF);
      wb_sel = S_LHU; #1;
      chk("lhu_data", fd_a[63:32], 32'h0000_80FF);
      wb_sel = S_LW; #1;
      chk("lw_data", fd_a[63:32], 32'h80FF_0000);
      wb_sel = S_LB; wb_alo = 2'd1; #1;
      chk("lb_a1_data", fd_a[63:32], 32'h0000_0000);

      // Priority EX/MEM > MEM/WB; x0 operand
      tick();
      idle();
      ex_set(5'd7, S_ALU, 32'hA);
      wb_set(5'd7, S_ALU, 32'hB);
      id_ex_advance = 1'b1;
      rs_addr = {5'd0, 5'd7}; rs_data = {32'h99, 32'h77};
      #1;
      chk("prio_ex", fd_a[31:0], 32'hA);
      chk("prio_ex_src", 32'(fs_a[1:0]), 32'd1);
      chk("x0_data", fd_a[63:32], 32'h0);
      ex_we = 1'b0; #1;
      chk("prio_wb", fd_a[31:0], 32'hB);
      chk("prio_wb_src", 32'(fs_a[1:0]), 32'd2);
      ex_set(5'd0, S_ALU, 32'h55); #1;
      chk("x0_live_data", fd_a[63:32], 32'h0);
      chk("x0_live_src", 32'(fs_a[3:2]), 32'd0);

      // Retire into hold buffer during load-use stall
      tick();
      idle();
      ex_set(5'd8, S_LW, 32'h0);
      wb_set(5'd9, S_ALU, 32'h1234);
      rs_addr = {5'd8, 5'd9}; rs_data = {32'h88, 32'h99};
      #1;
      chk("hold_stall", 32'(st_a), 32'd1);
      chk("hold_pre_wb", fd_a[31:0], 32'h1234);
      tick();
      idle();
      wb_set(5'd8, S_LW, 32'h0); wb_rdata = 32'hDEAD_BEEF;
      id_ex_advance = 1'b1;
      #1;
      chk("hold_data", fd_a[31:0], 32'h1234);
      chk("hold_src", 32'(fs_a[1:0]), 32'd3);
      chk("hold_data_b", fd_b[31:0], 32'h1234);
      chk("hold_load_data", fd_a[63:32], 32'hDEAD_BEEF);
      chk("hold_load_src", 32'(fs_a[3:2]), 32'd2);
      chk("hold_nostall", 32'(st_a), 32'd0);
      tick();
      idle();
      #1;
      chk("clr_data0", fd_a[31:0], 32'h99);
      chk("clr_src", 32'(fs_a), 32'd0);
      chk("clr_data1", fd_a[63:32], 32'h88);

      // Overflow: depth 2 vs depth 1
      wb_set(5'd10, S_ALU, 32'h100);
      tick();
      wb_set(5'd11, S_ALU, 32'h200);
      tick();
      idle();
      rs_addr = {5'd11, 5'd10}; rs_data = {32'hB0, 32'hA0};
      #1;
      chk("ov2_d0", fd_a[31:0], 32'h100);
      chk("ov2_d1", fd_a[63:32], 32'h200);
      chk("ov2_src", 32'(fs_a), 32'hF);
      chk("ov2_flag", 32'(ov_a), 32'd0);
      chk("ov1_flag", 32'(ov_b), 32'd1);
      chk("ov1_d0", fd_b[31:0], 32'hA0);
      chk("ov1_d1", fd_b[63:32], 32'h200);
      wb_set(5'd10, S_ALU, 32'h300);
      tick();
      idle();
      #1;
      chk("ovw_a_d0", fd_a[31:0], 32'h300);
      chk("ovw_a_d1", fd_a[63:32], 32'h200);
      chk("ovw_a_flag", 32'(ov_a), 32'd0);
      chk("ovw_b_d0", fd_b[31:0], 32'h300);
      chk("ovw_b_d1", fd_b[63:32], 32'hB0);
      chk("ovw_b_src1", 32'(fs_b[3:2]), 32'd0);

      // Freeze: no capture, no clear, outputs stable
      pipe_freeze = 1'b1; id_ex_advance = 1'b1;
      wb_set(5'd12, S_ALU, 32'h400);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("frz_d0", fd_a[31:0], 32'h300);
         chk("frz_d1", fd_a[63:32], 32'h200);
         chk("frz_ov_b", 32'(ov_b), 32'd1);
      end
      idle();
      rs_addr = {5'd11, 5'd12}; rs_data = {32'hB1, 32'hC1};
      #1;
      chk("frz_nocap", fd_a[31:0], 32'hC1);
      chk("frz_nocap_src", 32'(fs_a[1:0]), 32'd0);
      chk("frz_kept", fd_a[63:32], 32'h200);
      id_ex_advance = 1'b1;
      tick();
      idle();
      rs_addr = {5'd11, 5'd10}; rs_data = {32'hB2, 32'hA2};
      #1;
      chk("adv_clr", fd_a[31:0], 32'hA2);
      chk("adv_clr_src", 32'(fs_a), 32'd0);
      chk("ov_sticky", 32'(ov_b), 32'd1);

      // Reset during a stall with a retire pending
      ex_set(5'd13, S_LW, 32'h0);
      wb_set(5'd14, S_ALU, 32'h77);
      rs_addr = {5'd1, 5'd13};
      #1;
      chk("rst_mid_stall", 32'(st_a), 32'd1);
      rst = 1'b1;
      tick();
      idle();
      rs_addr = {5'd14, 5'd13}; rs_data = {32'hE, 32'hD};
      #1;
      chk("rstm_stall", 32'(st_a), 32'd0);
      chk("rstm_d0", fd_a[31:0], 32'hD);
      chk("rstm_d1", fd_a[63:32], 32'hE);
      chk("rstm_src", 32'(fs_a), 32'd0);
      chk("rstm_ov_b", 32'(ov_b), 32'd0);
`ifdef FWD_PERF_CNT_EN
      chk("perf_lu_rst", plu_a, 32'd0);
      chk("perf_fwd_rst", pfw_a, 32'd0);
`endif
      rst = 1'b0;
      ex_set(5'd13, S_LW, 32'h0);
      tick();
      tick();
      ex_set(5'd13, S_ALU, 32'h5);
      tick();
      idle();
      #1;
`ifdef FWD_PERF_CNT_EN
      chk("perf_lu_cnt", plu_a, 32'd2);
      chk("perf_fwd_cnt", pfw_a, 32'd1);
`endif
      chk("post_stall", 32'(st_a), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
